// File: rtl/single_mips_load_store_unit.sv
// MIPS load/store unit: sub-word loads and stores over a word-only memory.
// Byte/half stores use a stalled two-cycle read-modify-write.
module single_mips_load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MEM_RD,
  input  logic                  MEM_WR,
  input  logic [1:0]            SIZE,
  input  logic                  LD_SIGNED,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  STALL,
  output logic                  ERR_VALID,
  output logic [ADDR_WIDTH-1:0] BAD_ADDR,
  input  logic                  ERR_CLR,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [DATA_WIDTH-1:0] rmw_data;
  logic                  rmw_load;
  logic [DATA_WIDTH-1:0] merged;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  req;
  logic                  misaligned;
  logic                  err_set;
  logic [4:0]            bsh;
  logic [4:0]            hsh;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign word_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign is_byte    = (SIZE == 2'b00);
  assign is_half    = (SIZE == 2'b01);
  assign is_word    = SIZE[1];
  assign req        = MEM_RD | MEM_WR;
  assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  assign err_set    = (state == IDLE) & req & misaligned;
  assign bsh        = {addr[1:0], 3'b000};
  assign hsh        = {addr[1], 4'b0000};
  assign byte_sel   = mem_rdata[bsh +: 8];
  assign half_sel   = mem_rdata[hsh +: 16];

  always_comb begin
    merged = mem_rdata;
    if (is_byte) merged[bsh +: 8] = store_data[7:0];
    else         merged[hsh +: 16] = store_data[15:0];
  end

  always_comb begin
    next_state = state;
    mem_addr   = addr;
    mem_wr_en  = 1'b0;
    mem_wdata  = '0;
    STALL      = 1'b0;
    load_data  = '0;
    rmw_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && misaligned) begin
          mem_addr = addr;
        end else if (MEM_WR) begin
          mem_addr = word_addr;
          if (is_word) begin
            mem_wr_en = 1'b1;
            mem_wdata = store_data;
          end else begin
            STALL      = 1'b1;
            rmw_load   = 1'b1;
            next_state = RMW_WR;
          end
        end else if (MEM_RD) begin
          mem_addr = word_addr;
          unique case (1'b1)
            is_byte: load_data = {{24{LD_SIGNED & byte_sel[7]}}, byte_sel};
            is_half: load_data = {{16{LD_SIGNED & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
          endcase
        end
      end
      RMW_WR: begin
        mem_addr   = rmw_addr;
        mem_wdata  = rmw_data;
        mem_wr_en  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset drops any pending write immediately
    if (RST) begin
      mem_wr_en = 1'b0;
      STALL     = 1'b0;
      rmw_load  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else begin
      state <= next_state;
      if (rmw_load) begin
        rmw_addr <= word_addr;
        rmw_data <= merged;
      end
    end
  end

  // First error is kept unless cleared in the same cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_VALID <= 1'b0;
      BAD_ADDR  <= '0;
    end else if (err_set) begin
      ERR_VALID <= 1'b1;
      if (!ERR_VALID || ERR_CLR) BAD_ADDR <= addr;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
      BAD_ADDR  <= '0;
    end
  end

endmodule
